conv3x3_mac: RTL

Pipelined 3x3 convolution stage that sits directly downstream of the 3x3 sliding-window generator. Each valid window beat is multiplied by a loaded 3x3 signed kernel and summed with a bias. The sum is then shifted down, clamped to an 8-bit unsigned pixel (ReLU plus saturation), and emitted one result per accepted beat. Windows that straddle a row boundary are dropped using an internal column counter.

---
 rtl/conv3x3_mac.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_mac.sv
// -----------------------------------------------------------------------------
// conv3x3_mac
// Pipelined 3x3 convolution stage fed by a 3x3 sliding-window generator.
// Each accepted window beat is multiplied by a loaded signed 3x3 kernel,
// summed with a signed bias, shifted down, and clamped to an 8-bit unsigned
// pixel (ReLU plus saturation). Windows that straddle a row boundary, which
// are the first two beats of every row, are dropped using an internal
// column counter.
//
// Parameters
//   IMG_WIDTH   pixels per image row (period of the column counter)
//   SHIFT       arithmetic right shift applied before clamping (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   frame_start  forces the column count to 0 for the beat in this cycle
//   in_valid     window_in carries a window this cycle
//   window_in    nine unsigned 8-bit pixels, element k at [8k+7:8k]
//   wt_load      write strobe for one kernel coefficient (k order 0..8)
//   wt_data      signed 8-bit coefficient
//   bias_we      write strobe for bias_in
//   bias_in      signed 16-bit bias at accumulator scale
//   wt_ready     all 9 coefficients loaded; beats accepted only while 1
//   out_valid    pix_out holds a result (one cycle per result)
//   pix_out      unsigned 8-bit result, held while out_valid is 0
//   out_last     with out_valid, last result of a row
//
// Pipeline: S1 products, S2 three partial sums, S3 final sum plus bias,
// S4 shift and clamp into the output registers. No backpressure.
// -----------------------------------------------------------------------------
module conv3x3_mac #(
   parameter int IMG_WIDTH = 128,
   parameter int SHIFT     = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        in_valid,
   input  logic [71:0] window_in,
   input  logic        wt_load,
   input  logic [7:0]  wt_data,
   input  logic        bias_we,
   input  logic [15:0] bias_in,
   output logic        wt_ready,
   output logic        out_valid,
   output logic [7:0]  pix_out,
   output logic        out_last
);

   localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

   // {0,pixel} as 9-bit signed times a signed coefficient; exact in 17 bits.
   function automatic logic signed [16:0] px_mul(input logic [7:0] px,
                                                 input logic signed [7:0] c);
      logic signed [8:0] px_s;
      px_s   = $signed({1'b0, px});
      px_mul = 17'(px_s) * 17'(c);
   endfunction

   // ReLU plus saturation to an unsigned 8-bit pixel.
   function automatic logic [7:0] relu_sat(input logic signed [21:0] s);
      if (s < 22'sd0) begin
         relu_sat = 8'd0;
      end else if (s > 22'sd255) begin
         relu_sat = 8'd255;
      end else begin
         relu_sat = s[7:0];
      end
   endfunction

   // Kernel storage and load state
   logic signed [7:0]  coeff_r [0:8];
   logic [3:0]         idx_r;
   logic               wt_ready_r;
   logic signed [15:0] bias_r;

   // Column tracking
   logic [CW-1:0] col_r;
   logic [CW-1:0] col_cur_s;
   logic [CW-1:0] col_next_s;
   logic          accept_s;
   logic          keep_s;

   // Pipeline registers
   logic signed [16:0] prod_r [0:8];
   logic signed [15:0] bias1_r;
   logic               v1_r;
   logic               last1_r;
   logic signed [18:0] psum_r [0:2];
   logic signed [15:0] bias2_r;
   logic               v2_r;
   logic               last2_r;
   logic signed [21:0] acc_r;
   logic               v3_r;
   logic               last3_r;
   logic signed [21:0] shifted_s;

   logic               out_valid_r;
   logic [7:0]         pix_out_r;
   logic               out_last_r;

   // Beat acceptance and column bookkeeping; wt_load wins over a beat.
   always_comb begin
      accept_s   = in_valid & wt_ready_r & ~wt_load;
      col_cur_s  = frame_start ? {CW{1'b0}} : col_r;
      if (col_cur_s == COL_LAST) begin
         col_next_s = {CW{1'b0}};
      end else begin
         col_next_s = col_cur_s + CW'(1);
      end
      // Counts 0 and 1 are windows that wrap across the previous row.
      keep_s     = accept_s & (32'(col_cur_s) >= 32'd2);
      shifted_s  = acc_r >>> SHIFT;
   end

   // Coefficient writes; the 9th write arms wt_ready and wraps the index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 9; k++) begin
            coeff_r[k] <= 8'sd0;
         end
         idx_r      <= 4'd0;
         wt_ready_r <= 1'b0;
      end else if (wt_load) begin
         coeff_r[idx_r] <= wt_data;
         if (idx_r == 4'd8) begin
            idx_r      <= 4'd0;
            wt_ready_r <= 1'b1;
         end else begin
            idx_r      <= idx_r + 4'd1;
            wt_ready_r <= 1'b0;
         end
      end else begin
         idx_r      <= idx_r;
         wt_ready_r <= wt_ready_r;
      end
   end

   // Bias register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_r <= 16'sd0;
      end else if (bias_we) begin
         bias_r <= bias_in;
      end else begin
         bias_r <= bias_r;
      end
   end

   // Column counter: advances only on accepted beats, frame_start rezeros it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r <= {CW{1'b0}};
      end else if (accept_s) begin
         col_r <= col_next_s;
      end else if (frame_start) begin
         col_r <= {CW{1'b0}};
      end else begin
         col_r <= col_r;
      end
   end

   // S1: products and tags; kernel and bias are sampled here so a later
   // reload cannot disturb beats already in the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 9; k++) begin
            prod_r[k] <= 17'sd0;
         end
         bias1_r <= 16'sd0;
         v1_r    <= 1'b0;
         last1_r <= 1'b0;
      end else begin
         for (int k = 0; k < 9; k++) begin
            prod_r[k] <= px_mul(window_in[8*k +: 8], coeff_r[k]);
         end
         bias1_r <= bias_r;
         v1_r    <= keep_s;
         last1_r <= keep_s & (col_cur_s == COL_LAST);
      end
   end

   // S2: one partial sum per kernel row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < 3; j++) begin
            psum_r[j] <= 19'sd0;
         end
         bias2_r <= 16'sd0;
         v2_r    <= 1'b0;
         last2_r <= 1'b0;
      end else begin
         for (int j = 0; j < 3; j++) begin
            psum_r[j] <= 19'(prod_r[3*j]) + 19'(prod_r[3*j+1]) + 19'(prod_r[3*j+2]);
         end
         bias2_r <= bias1_r;
         v2_r    <= v1_r;
         last2_r <= last1_r;
      end
   end

   // S3: final sum plus sign-extended bias.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= 22'sd0;
         v3_r    <= 1'b0;
         last3_r <= 1'b0;
      end else begin
         acc_r   <= 22'(psum_r[0]) + 22'(psum_r[1]) + 22'(psum_r[2]) + 22'(bias2_r);
         v3_r    <= v2_r;
         last3_r <= last2_r;
      end
   end

   // S4: shift, clamp and register outputs; pix_out holds between results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         pix_out_r   <= 8'd0;
      end else begin
         out_valid_r <= v3_r;
         out_last_r  <= v3_r & last3_r;
         if (v3_r) begin
            pix_out_r <= relu_sat(shifted_s);
         end else begin
            pix_out_r <= pix_out_r;
         end
      end
   end

   assign wt_ready  = wt_ready_r;
   assign out_valid = out_valid_r;
   assign pix_out   = pix_out_r;
   assign out_last  = out_last_r;

endmodule
